// File: rtl/rst_seq_ctrl_pkg.sv
// rtl/rst_seq_ctrl_pkg.sv - shared types and constants for the reset sequencer
package rst_seq_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } rst_seq_state_e;

    // Defaults used by the top-level reset tree
    localparam int DEF_NUM_OUTS  = 3;
    localparam int DEF_STRETCH   = 8;
    localparam int DEF_DLY_WIDTH = 4;

endpackage

// File: rtl/rst_req_edge_det.sv
// rtl/rst_req_edge_det.sv - registered rising-edge detector for the software reset request
//
// Ports:
//   CLK        in   block clock
//   RST        in   asynchronous active-low reset
//   i_req      in   software reset request level
//   o_req_edge out  high in the cycle where i_req is high and was low on the previous edge
module rst_req_edge_det (
    input  logic CLK,
    input  logic RST,
    input  logic i_req,
    output logic o_req_edge
);

    logic r_req_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_req_q <= 1'b0;
        end else begin
            r_req_q <= i_req;
        end
    end

    assign o_req_edge = i_req & ~r_req_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - reset sequencer: stretch, then release per-domain resets in index order
//
// Ports:
//   CLK         in   reference clock (always-on domain)
//   RST         in   asynchronous active-low system reset
//   SW_RST_REQ  in   software reset request, rising edge restarts the sequence
//   DLY_CFG     in   inter-release gap minus one, latched when HOLD ends
//   RST_OUT     out  active-low reset requests, bit 0 released first
//   SEQ_DONE    out  high while every output is released
//   SW_RST_ACK  out  one-cycle pulse per accepted software request
module rst_seq_ctrl
    import rst_seq_ctrl_pkg::*;
#(
    parameter int NUM_OUTS  = DEF_NUM_OUTS,
    parameter int STRETCH   = DEF_STRETCH,
    parameter int DLY_WIDTH = DEF_DLY_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 SW_RST_REQ,
    input  logic [DLY_WIDTH-1:0] DLY_CFG,
    output logic [NUM_OUTS-1:0]  RST_OUT,
    output logic                 SEQ_DONE,
    output logic                 SW_RST_ACK
);

    localparam int HOLD_W = $clog2(STRETCH);
    localparam int IDX_W  = $clog2(NUM_OUTS);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(STRETCH - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_OUTS - 1);

    rst_seq_state_e       r_state,    w_state_nxt;
    logic [HOLD_W-1:0]    r_hold_cnt, w_hold_cnt_nxt;
    logic [DLY_WIDTH-1:0] r_gap_cnt,  w_gap_cnt_nxt;
    logic [DLY_WIDTH-1:0] r_dly_q,    w_dly_q_nxt;
    logic [IDX_W-1:0]     r_idx,      w_idx_nxt;
    logic [NUM_OUTS-1:0]  r_rst_out,  w_rst_out_nxt;
    logic                 r_done,     w_done_nxt;
    logic                 r_ack,      w_ack_nxt;
    logic                 w_req_edge;

    rst_req_edge_det u_edge_det (
        .CLK        (CLK),
        .RST        (RST),
        .i_req      (SW_RST_REQ),
        .o_req_edge (w_req_edge)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
            r_gap_cnt  <= '0;
            r_dly_q    <= '0;
            r_idx      <= '0;
            r_rst_out  <= '0;
            r_done     <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_dly_q    <= w_dly_q_nxt;
            r_idx      <= w_idx_nxt;
            r_rst_out  <= w_rst_out_nxt;
            r_done     <= w_done_nxt;
            r_ack      <= w_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_dly_q_nxt    = r_dly_q;
        w_idx_nxt      = r_idx;
        w_rst_out_nxt  = r_rst_out;
        w_done_nxt     = r_done;
        w_ack_nxt      = 1'b0;

        case (r_state)
            ST_HOLD: begin
                if (r_hold_cnt == LAST_HOLD) begin
                    w_state_nxt    = ST_RELEASE;
                    w_hold_cnt_nxt = '0;
                    w_gap_cnt_nxt  = '0;
                    w_idx_nxt      = '0;
                    w_dly_q_nxt    = DLY_CFG;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (r_gap_cnt == r_dly_q) begin
                    // Outputs release strictly in index order, so shifting a 1 in
                    // from bit 0 releases exactly output r_idx.
                    w_rst_out_nxt = {r_rst_out[NUM_OUTS-2:0], 1'b1};
                    w_gap_cnt_nxt = '0;
                    w_idx_nxt     = r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end
            ST_RUN: begin
            end
            default: begin
                w_state_nxt = ST_HOLD;
            end
        endcase

        // Software restart wins over sequencing; ignored while already holding.
        if (r_state != ST_HOLD && w_req_edge) begin
            w_state_nxt    = ST_HOLD;
            w_hold_cnt_nxt = '0;
            w_gap_cnt_nxt  = '0;
            w_idx_nxt      = '0;
            w_rst_out_nxt  = '0;
            w_done_nxt     = 1'b0;
            w_ack_nxt      = 1'b1;
        end
    end

    assign RST_OUT    = r_rst_out;
    assign SEQ_DONE   = r_done;
    assign SW_RST_ACK = r_ack;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - directed self-checking bench for rst_seq_ctrl
module tb_rst_seq_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       SW_RST_REQ = 1'b0;
    logic [3:0] DLY_CFG = 4'd3;
    logic [2:0] RST_OUT;
    logic       SEQ_DONE;
    logic       SW_RST_ACK;

    int n_vec  = 0;
    int n_miss = 0;
    int edge_no = 0;
    int ack_cnt;

    rst_seq_ctrl #(.NUM_OUTS(3), .STRETCH(8), .DLY_WIDTH(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SW_RST_REQ (SW_RST_REQ),
        .DLY_CFG    (DLY_CFG),
        .RST_OUT    (RST_OUT),
        .SEQ_DONE   (SEQ_DONE),
        .SW_RST_ACK (SW_RST_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    // Advance to just after the given rising edge (counted from reset release).
    task automatic adv_to(input int e);
        while (edge_no < e) begin
            @(posedge CLK);
            edge_no++;
        end
        #1;
    endtask

    task automatic do_reset(input logic [3:0] dly);
        @(negedge CLK);
        RST = 1'b0;
        SW_RST_REQ = 1'b0;
        DLY_CFG = dly;
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        edge_no = 0;
    endtask

    always @(negedge CLK) begin
        if (RST) chk("done_eq_and", {31'd0, SEQ_DONE}, {31'd0, &RST_OUT});
    end

    initial begin
        // Reset state, including a request coincident with RST low
        RST = 1'b0;
        SW_RST_REQ = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_out_in_reset", {29'd0, RST_OUT}, 32'd0);
        chk("done_in_reset", {31'd0, SEQ_DONE}, 32'd0);
        chk("ack_in_reset", {31'd0, SW_RST_ACK}, 32'd0);

        // Power-on sequence with DLY_CFG = 3
        do_reset(4'd3);
        adv_to(11); chk("po_e11", {29'd0, RST_OUT}, 32'd0);
        adv_to(12); chk("po_e12", {29'd0, RST_OUT}, 32'd1);
        adv_to(15); chk("po_e15", {29'd0, RST_OUT}, 32'd1);
        adv_to(16); chk("po_e16", {29'd0, RST_OUT}, 32'd3);
        adv_to(19); chk("po_e19", {29'd0, RST_OUT}, 32'd3);
                    chk("po_done_e19", {31'd0, SEQ_DONE}, 32'd0);
        adv_to(20); chk("po_e20", {29'd0, RST_OUT}, 32'd7);
                    chk("po_done_e20", {31'd0, SEQ_DONE}, 32'd1);

        // One-cycle software request in RUN, seen at edge 26
        adv_to(25); SW_RST_REQ = 1'b1;
        adv_to(26); chk("sw_rst_out", {29'd0, RST_OUT}, 32'd0);
                    chk("sw_done", {31'd0, SEQ_DONE}, 32'd0);
                    chk("sw_ack", {31'd0, SW_RST_ACK}, 32'd1);
        SW_RST_REQ = 1'b0;
        adv_to(27); chk("sw_ack_drop", {31'd0, SW_RST_ACK}, 32'd0);
        adv_to(37); chk("sw_e37", {29'd0, RST_OUT}, 32'd0);
        adv_to(38); chk("sw_e38", {29'd0, RST_OUT}, 32'd1);
        adv_to(46); chk("sw_e46", {29'd0, RST_OUT}, 32'd7);

        // Request level held for 20 cycles: one ACK, one restart
        adv_to(47); SW_RST_REQ = 1'b1;
        ack_cnt = 0;
        for (int i = 48; i <= 67; i++) begin
            adv_to(i);
            if (SW_RST_ACK) ack_cnt++;
        end
        chk("held_ack_cnt", ack_cnt, 1);
        chk("held_e67", {29'd0, RST_OUT}, 32'd3);
        SW_RST_REQ = 1'b0;
        adv_to(68); chk("held_e68", {29'd0, RST_OUT}, 32'd7);

        // Request during HOLD is ignored and does not shift timing
        do_reset(4'd3);
        adv_to(3); SW_RST_REQ = 1'b1;
        adv_to(4); chk("hold_req_ack", {31'd0, SW_RST_ACK}, 32'd0);
        SW_RST_REQ = 1'b0;
        adv_to(11); chk("hold_req_e11", {29'd0, RST_OUT}, 32'd0);
        adv_to(12); chk("hold_req_e12", {29'd0, RST_OUT}, 32'd1);

        // Asynchronous RST mid-RELEASE
        adv_to(16); chk("mid_e16", {29'd0, RST_OUT}, 32'd3);
        #2 RST = 1'b0;
        #1 chk("async_rst_out", {29'd0, RST_OUT}, 32'd0);
        do_reset(4'd3);
        adv_to(11); chk("restart_e11", {29'd0, RST_OUT}, 32'd0);
        adv_to(12); chk("restart_e12", {29'd0, RST_OUT}, 32'd1);

        // DLY_CFG change after latching has no effect until the next sequence
        do_reset(4'd3);
        adv_to(8); DLY_CFG = 4'd7;
        adv_to(12); chk("late_cfg_e12", {29'd0, RST_OUT}, 32'd1);
        adv_to(16); chk("late_cfg_e16", {29'd0, RST_OUT}, 32'd3);
        adv_to(20); chk("late_cfg_e20", {29'd0, RST_OUT}, 32'd7);
        adv_to(21); SW_RST_REQ = 1'b1;
        adv_to(22); chk("late_cfg_ack", {31'd0, SW_RST_ACK}, 32'd1);
        SW_RST_REQ = 1'b0;
        adv_to(37); chk("new_cfg_e37", {29'd0, RST_OUT}, 32'd0);
        adv_to(38); chk("new_cfg_e38", {29'd0, RST_OUT}, 32'd1);

        // DLY_CFG = 0: back-to-back releases
        do_reset(4'd0);
        adv_to(8);  chk("d0_e8", {29'd0, RST_OUT}, 32'd0);
        adv_to(9);  chk("d0_e9", {29'd0, RST_OUT}, 32'd1);
        adv_to(10); chk("d0_e10", {29'd0, RST_OUT}, 32'd3);
                    chk("d0_done_e10", {31'd0, SEQ_DONE}, 32'd0);
        adv_to(11); chk("d0_e11", {29'd0, RST_OUT}, 32'd7);
                    chk("d0_done_e11", {31'd0, SEQ_DONE}, 32'd1);

        // DLY_CFG all-ones: 16-cycle gap
        do_reset(4'd15);
        adv_to(23); chk("d15_e23", {29'd0, RST_OUT}, 32'd0);
        adv_to(24); chk("d15_e24", {29'd0, RST_OUT}, 32'd1);
        adv_to(39); chk("d15_e39", {29'd0, RST_OUT}, 32'd1);
        adv_to(40); chk("d15_e40", {29'd0, RST_OUT}, 32'd3);
        adv_to(56); chk("d15_e56", {29'd0, RST_OUT}, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Reset sequencer that generates the per-domain reset requests later consumed by each domain's reset synchronizer.
- After the system reset is released, it holds all outputs asserted for a stretch period, then releases them one at a time in index order, with a configurable gap between releases.
- A software reset request re-asserts all outputs and restarts the sequence.
- Sits in the always-on reference-clock domain at the top of the reset tree.

Parameters:
- NUM_OUTS, 3, number of sequenced reset outputs; must be >= 2.
- STRETCH, 8, cycles all outputs stay asserted after entering HOLD; must be >= 2.
- DLY_WIDTH, 4, width of the inter-release gap configuration.

Ports:
- CLK  input  1  single block clock.
- RST  input  1  asynchronous, active-low reset.
- SW_RST_REQ  input  1  software reset request; synchronous to CLK; rising edge is significant.
- DLY_CFG  input  DLY_WIDTH  gap between consecutive releases, minus 1 (gap = DLY_CFG+1 cycles).
- RST_OUT  output  NUM_OUTS  active-low reset requests; bit 0 is released first.
- SEQ_DONE  output  1  high while all outputs are released.
- SW_RST_ACK  output  1  one-cycle pulse acknowledging an accepted software request.

Behaviour:
- All outputs are registered.
- While RST is low, asynchronously: RST_OUT = 0, SEQ_DONE = 0, SW_RST_ACK = 0, state = HOLD, counters = 0, idx = 0, request history register = 0.
- Edge numbering: edge 1 is the first CLK rising edge after RST deasserts.
- FSM states: HOLD, RELEASE, RUN.
- HOLD:
  - cnt increments each edge.
  - Edge on which cnt == STRETCH-1 -> go to RELEASE, cnt = 0, idx = 0, latch DLY_CFG into dly_q.
  - From reset, RELEASE is entered on edge STRETCH.
- RELEASE:
  - cnt increments each edge.
  - Edge on which cnt == dly_q -> RST_OUT[idx] = 1, cnt = 0, idx = idx+1.
  - The edge that releases idx NUM_OUTS-1 also sets SEQ_DONE = 1 and moves to RUN.
  - Output k is released on edge STRETCH + (k+1)*(DLY_CFG+1).
  - Released bits stay high. DLY_CFG changes after latching have no effect until the next sequence.
- RUN: hold all outputs; wait for a software request.
- Software request:
  - req_edge = SW_RST_REQ & ~req_q, where req_q is SW_RST_REQ registered every edge.
  - In RELEASE or RUN, on the edge where req_edge is 1: RST_OUT = 0, SEQ_DONE = 0, SW_RST_ACK = 1 for exactly one cycle, state = HOLD, cnt = 0, idx = 0.
  - In HOLD, req_edge is ignored (no ACK) and cnt is not restarted.
  - A level held high generates only one request; it must drop and rise again to re-trigger.
- RST assertion at any point (mid-HOLD, mid-RELEASE, coincident with a request) immediately forces the reset values. No ACK is produced for a request coincident with RST low.
- DLY_CFG = 0: releases occur on consecutive edges.
- DLY_CFG = all-ones: gap of 2^DLY_WIDTH cycles. cnt is DLY_WIDTH bits wide, sufficient without overflow.
- The HOLD counter is $clog2(STRETCH) bits. idx is $clog2(NUM_OUTS) bits.
- SEQ_DONE == &RST_OUT at all times; this is an assertion property.

Decomposition:
- Shared package holds:
  - state encoding localparams (HOLD = 2'd0, RELEASE = 2'd1, RUN = 2'd2);
  - default STRETCH / NUM_OUTS constants used by the top-level reset tree.
- One natural sub-module: rst_req_edge_det. It is a registered rising-edge detector on SW_RST_REQ, with async active-low reset on CLK/RST, producing req_edge.

Test Plan:
- Power-on: RST low 5 cycles then high, DLY_CFG = 3 -> RST_OUT = 000 until edge 12; 001 at 12, 011 at 16, 111 at 20. SEQ_DONE rises at edge 20.
- DLY_CFG = 0 -> RST_OUT steps 001/011/111 on edges 9/10/11. SEQ_DONE at edge 11.
- In RUN, pulse SW_RST_REQ for 1 cycle at edge E -> RST_OUT = 000 and SEQ_DONE = 0 after E. SW_RST_ACK is high only for cycle E..E+1. Re-release 001 at E+8+(DLY_CFG+1).
- SW_RST_REQ held high 20 cycles during RUN -> exactly one ACK and one restart. A request asserted during HOLD -> no ACK, and release timing unchanged.
- Assert RST mid-RELEASE with RST_OUT = 011 -> RST_OUT = 000 immediately (asynchronously, before the next CLK edge). The sequence restarts from edge 1 after release.
- Change DLY_CFG from 3 to 7 after edge 8 -> gaps remain 4 cycles. The new value applies after the next software request.
